// File: rtl/reg_rename_file_pkg.sv
// Shared types and constants for the rename register file.
// Tag value NULL_ROB_IDX means the architectural value is current (no pending producer).
package reg_rename_file_pkg;

  localparam int REG_BIT    = 5;
  localparam int ROB_IDX_LN = 4;
  localparam int ROB_BIT    = ROB_IDX_LN;
  localparam int WORD_LN    = 32;
  localparam int NUM_REGS   = 1 << REG_BIT;

  typedef logic [REG_BIT-1:0] reg_idx_t;
  typedef logic [ROB_BIT-1:0] rob_idx_t;
  typedef logic [WORD_LN-1:0] word_t;

  localparam word_t    ZERO_WORD    = '0;
  localparam reg_idx_t ZERO_REG_IDX = '0;
  localparam rob_idx_t NULL_ROB_IDX = '0;

endpackage

// File: rtl/reg_rename_file_if.sv
// Decode read/rename and ROB commit/rollback bundle for the rename register file.
// master = ID/ROB side driving requests, slave = register file.
interface reg_rename_file_if;
  import reg_rename_file_pkg::*;

  reg_idx_t id_rs1;
  reg_idx_t id_rs2;
  rob_idx_t id_src1;
  rob_idx_t id_src2;
  word_t    id_val1;
  word_t    id_val2;
  logic     id_rn_ena;
  reg_idx_t id_rn_rd;
  rob_idx_t id_rn_idx;
  logic     reg_wr_ena;
  reg_idx_t reg_wr_rd;
  word_t    reg_wr_val;
  rob_idx_t reg_wr_idx;
  logic     rob_rb_ena;

  modport master (
    output id_rs1, id_rs2, id_rn_ena, id_rn_rd, id_rn_idx,
    output reg_wr_ena, reg_wr_rd, reg_wr_val, reg_wr_idx, rob_rb_ena,
    input  id_src1, id_src2, id_val1, id_val2
  );

  modport slave (
    input  id_rs1, id_rs2, id_rn_ena, id_rn_rd, id_rn_idx,
    input  reg_wr_ena, reg_wr_rd, reg_wr_val, reg_wr_idx, rob_rb_ena,
    output id_src1, id_src2, id_val1, id_val2
  );

endinterface

// File: rtl/reg_rename_file_rf_read_port.sv
// One source-operand read: x0 forced to zero, same-cycle commit bypass on tag match.
// Purely combinational, zero latency; no backpressure.
module reg_rename_file_rf_read_port
  import reg_rename_file_pkg::*;
(
  input  reg_idx_t rs,
  input  rob_idx_t cur_tag,
  input  word_t    cur_val,
  input  logic     wr_ena,
  input  reg_idx_t wr_rd,
  input  word_t    wr_val,
  input  rob_idx_t wr_idx,
  output rob_idx_t src,
  output word_t    val
);

  always_comb begin
    src = cur_tag;
    val = cur_val;
    if (rs == ZERO_REG_IDX) begin
      src = NULL_ROB_IDX;
      val = ZERO_WORD;
    end else if (wr_ena && wr_rd == rs && wr_idx == cur_tag) begin
      // The producer retires this cycle: hand its value straight to decode.
      src = NULL_ROB_IDX;
      val = wr_val;
    end
  end

endmodule

// File: rtl/reg_rename_file.sv
// Architectural register file with ROB rename tags: two bypassed read ports, rename, commit, rollback.
// Reads are combinational; updates take effect at the next clock; rdy low freezes all state.
module reg_rename_file
  import reg_rename_file_pkg::*;
(
  input logic              clk,
  input logic              rst,
  input logic              rdy,
  reg_rename_file_if.slave rf
);

  word_t    val_q [NUM_REGS];
  word_t    val_d [NUM_REGS];
  rob_idx_t tag_q [NUM_REGS];
  rob_idx_t tag_d [NUM_REGS];

  reg_rename_file_rf_read_port u_rd1 (
    .rs      (rf.id_rs1),
    .cur_tag (tag_q[rf.id_rs1]),
    .cur_val (val_q[rf.id_rs1]),
    .wr_ena  (rf.reg_wr_ena),
    .wr_rd   (rf.reg_wr_rd),
    .wr_val  (rf.reg_wr_val),
    .wr_idx  (rf.reg_wr_idx),
    .src     (rf.id_src1),
    .val     (rf.id_val1)
  );

  reg_rename_file_rf_read_port u_rd2 (
    .rs      (rf.id_rs2),
    .cur_tag (tag_q[rf.id_rs2]),
    .cur_val (val_q[rf.id_rs2]),
    .wr_ena  (rf.reg_wr_ena),
    .wr_rd   (rf.reg_wr_rd),
    .wr_val  (rf.reg_wr_val),
    .wr_idx  (rf.reg_wr_idx),
    .src     (rf.id_src2),
    .val     (rf.id_val2)
  );

  always_comb begin
    val_d = val_q;
    tag_d = tag_q;
    if (rdy) begin
      if (rf.reg_wr_ena && rf.reg_wr_rd != ZERO_REG_IDX) begin
        // Value lands even on a stale commit; only a matching tag is cleared.
        val_d[rf.reg_wr_rd] = rf.reg_wr_val;
        if (tag_q[rf.reg_wr_rd] == rf.reg_wr_idx) begin
          tag_d[rf.reg_wr_rd] = NULL_ROB_IDX;
        end
      end
      if (rf.id_rn_ena && rf.id_rn_rd != ZERO_REG_IDX) begin
        tag_d[rf.id_rn_rd] = rf.id_rn_idx;
      end
      // Rollback drops every rename but keeps the commit that triggered it.
      if (rf.rob_rb_ena) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          tag_d[i] = NULL_ROB_IDX;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        val_q[i] <= ZERO_WORD;
        tag_q[i] <= NULL_ROB_IDX;
      end
    end else begin
      val_q <= val_d;
      tag_q <= tag_d;
    end
  end

endmodule

// File: tb/tb_reg_rename_file.sv
// Directed bench for reg_rename_file: rename, bypass, stale commit, rollback, x0, rdy stall, reset.
module tb_reg_rename_file;
  import reg_rename_file_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  reg_rename_file_if rf_if ();

  reg_rename_file dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .rf  (rf_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rf_if.id_rn_ena  = 1'b0;
    rf_if.id_rn_rd   = '0;
    rf_if.id_rn_idx  = '0;
    rf_if.reg_wr_ena = 1'b0;
    rf_if.reg_wr_rd  = '0;
    rf_if.reg_wr_val = '0;
    rf_if.reg_wr_idx = '0;
    rf_if.rob_rb_ena = 1'b0;
  endtask

  task automatic rename(input int rd, input int idx);
    rf_if.id_rn_ena = 1'b1;
    rf_if.id_rn_rd  = reg_idx_t'(rd);
    rf_if.id_rn_idx = rob_idx_t'(idx);
  endtask

  task automatic commit(input int rd, input int idx, input logic [31:0] v);
    rf_if.reg_wr_ena = 1'b1;
    rf_if.reg_wr_rd  = reg_idx_t'(rd);
    rf_if.reg_wr_idx = rob_idx_t'(idx);
    rf_if.reg_wr_val = v;
  endtask

  task automatic rd(input int r1, input int r2);
    rf_if.id_rs1 = reg_idx_t'(r1);
    rf_if.id_rs2 = reg_idx_t'(r2);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    rdy = 1'b1;
    idle();
    rd(0, 0);
    tick();
    tick();
    rst = 1'b0;

    rd(5, 0);
    chk("rst_src1", 32'(rf_if.id_src1), 32'h0);
    chk("rst_val1", rf_if.id_val1, 32'h0);
    chk("rst_src2", 32'(rf_if.id_src2), 32'h0);
    chk("rst_val2", rf_if.id_val2, 32'h0);

    // Rename is invisible in its own cycle.
    rename(5, 3);
    rd(5, 0);
    chk("rn_same_cyc_src", 32'(rf_if.id_src1), 32'h0);
    tick();
    idle();
    rd(5, 0);
    chk("rn_next_src", 32'(rf_if.id_src1), 32'h3);

    commit(5, 3, 32'hDEADBEEF);
    rd(5, 5);
    chk("byp_src", 32'(rf_if.id_src1), 32'h0);
    chk("byp_val", rf_if.id_val1, 32'hDEADBEEF);
    chk("byp_val_p2", rf_if.id_val2, 32'hDEADBEEF);
    tick();
    idle();
    rd(5, 0);
    chk("cmt_src", 32'(rf_if.id_src1), 32'h0);
    chk("cmt_val", rf_if.id_val1, 32'hDEADBEEF);

    // Stale commit: value written, younger tag kept.
    rename(5, 3);
    tick();
    rename(5, 7);
    tick();
    idle();
    rd(5, 0);
    chk("rerename_src", 32'(rf_if.id_src1), 32'h7);
    commit(5, 3, 32'h11);
    rd(5, 0);
    chk("stale_nobyp_src", 32'(rf_if.id_src1), 32'h7);
    chk("stale_nobyp_val", rf_if.id_val1, 32'hDEADBEEF);
    tick();
    idle();
    rd(5, 0);
    chk("stale_src", 32'(rf_if.id_src1), 32'h7);
    chk("stale_val", rf_if.id_val1, 32'h11);
    commit(5, 7, 32'h22);
    rd(0, 5);
    chk("young_byp_src", 32'(rf_if.id_src2), 32'h0);
    chk("young_byp_val", rf_if.id_val2, 32'h22);
    tick();
    idle();
    rd(5, 0);
    chk("young_src", 32'(rf_if.id_src1), 32'h0);
    chk("young_val", rf_if.id_val1, 32'h22);

    // Rename overrides the tag clear on the same register.
    rename(5, 3);
    tick();
    commit(5, 3, 32'h33);
    rename(5, 9);
    tick();
    idle();
    rd(5, 0);
    chk("rn_over_clr_src", 32'(rf_if.id_src1), 32'h9);
    chk("rn_over_clr_val", rf_if.id_val1, 32'h33);

    // Rollback with a same-cycle commit and rename.
    rename(1, 2);
    tick();
    rename(2, 4);
    tick();
    idle();
    rd(1, 2);
    chk("pre_rb_src1", 32'(rf_if.id_src1), 32'h2);
    chk("pre_rb_src2", 32'(rf_if.id_src2), 32'h4);
    rf_if.rob_rb_ena = 1'b1;
    commit(1, 2, 32'h1000);
    rename(3, 5);
    rd(1, 2);
    chk("rb_cyc_src2", 32'(rf_if.id_src2), 32'h4);
    tick();
    idle();
    rd(1, 2);
    chk("rb_val1", rf_if.id_val1, 32'h1000);
    chk("rb_src1", 32'(rf_if.id_src1), 32'h0);
    chk("rb_src2", 32'(rf_if.id_src2), 32'h0);
    rd(3, 5);
    chk("rb_rn_drop", 32'(rf_if.id_src1), 32'h0);
    chk("rb_x5_src", 32'(rf_if.id_src2), 32'h0);

    // x0 ignores rename and commit, including the bypass path.
    rename(0, 6);
    commit(0, 0, 32'hFF);
    rd(0, 0);
    chk("x0_byp_val", rf_if.id_val1, 32'h0);
    tick();
    idle();
    rd(0, 0);
    chk("x0_src", 32'(rf_if.id_src1), 32'h0);
    chk("x0_val", rf_if.id_val2, 32'h0);

    // rdy low freezes state; rdy high lets the same ops land.
    rdy = 1'b0;
    rename(6, 5);
    commit(7, 0, 32'h44);
    tick();
    rd(6, 7);
    chk("stall_src", 32'(rf_if.id_src1), 32'h0);
    idle();
    rd(6, 7);
    chk("stall_val", rf_if.id_val2, 32'h0);
    rdy = 1'b1;
    rename(6, 5);
    commit(7, 0, 32'h44);
    tick();
    idle();
    rd(6, 7);
    chk("resume_src", 32'(rf_if.id_src1), 32'h5);
    chk("resume_val", rf_if.id_val2, 32'h44);

    // Reset wins over a concurrent rename/commit.
    rst = 1'b1;
    rename(8, 3);
    commit(7, 0, 32'h55);
    tick();
    rst = 1'b0;
    idle();
    rd(6, 7);
    chk("rst_pri_src", 32'(rf_if.id_src1), 32'h0);
    chk("rst_pri_val", rf_if.id_val2, 32'h0);
    rd(8, 5);
    chk("rst_pri_rn", 32'(rf_if.id_src1), 32'h0);
    chk("rst_pri_x5", rf_if.id_val2, 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
